// File: rtl/pipe_pkg.sv
// Shared pipeline constants and the per-cycle action decode used by the stage registers.
package pipe_pkg;

  localparam int unsigned IFID_W            = 64;
  localparam logic [IFID_W-1:0] NOP_BUBBLE  = '0;
  localparam int unsigned DEFAULT_CTX_DEPTH = 2;

  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_LOAD,
    ACT_RESTORE,
    ACT_SAVE,
    ACT_FLUSH
  } stage_act_e;

  // Exactly one action per cycle: flush > save > restore > load > hold.
  function automatic stage_act_e pick_action(input logic flush, input logic save,
                                             input logic restore, input logic load);
    if (flush)        return ACT_FLUSH;
    else if (save)    return ACT_SAVE;
    else if (restore) return ACT_RESTORE;
    else if (load)    return ACT_LOAD;
    else              return ACT_HOLD;
  endfunction

endpackage

// File: rtl/pipe_stage_ctx_reg_lifo.sv
// Parametrised LIFO for parking stage contexts; count saturates at 0 and DEPTH.
module ctx_lifo #(
  parameter int unsigned W     = 65,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  push_data,
  output logic [W-1:0]  pop_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !push && !empty;
  assign wr_idx  = AW'(count);
  assign rd_idx  = AW'(count - CW'(1));
  assign pop_data = mem[rd_idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (do_push) begin
      count <= count + CW'(1);
    end else if (do_pop) begin
      count <= count - CW'(1);
    end
  end

  // Storage is intentionally unreset; entries above count are never read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/pipe_stage_ctx_reg.sv
// Inter-stage pipeline register with stall/flush and a nested-interrupt context stack.
module pipe_stage_ctx_reg
  import pipe_pkg::*;
#(
  parameter int unsigned        DATA_W    = IFID_W,
  parameter int unsigned        CTX_DEPTH = DEFAULT_CTX_DEPTH,
  parameter logic [DATA_W-1:0]  BUBBLE    = DATA_W'(NOP_BUBBLE),
  localparam int unsigned       CW        = $clog2(CTX_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              write_en,
  input  logic              flush,
  input  logic              int_save,
  input  logic              int_restore,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic [CW-1:0]     ctx_count,
  output logic              ctx_full,
  output logic              ctx_empty,
  output logic              ctx_err
);

  stage_act_e      act;
  logic            lifo_push;
  logic            lifo_pop;
  logic [DATA_W:0] pop_data;

  assign act       = pick_action(flush, int_save, int_restore, write_en);
  assign lifo_push = (act == ACT_SAVE);
  assign lifo_pop  = (act == ACT_RESTORE);

  ctx_lifo #(
    .W     (DATA_W + 1),
    .DEPTH (CTX_DEPTH)
  ) u_lifo (
    .clk       (clk),
    .reset     (reset),
    .push      (lifo_push),
    .pop       (lifo_pop),
    .push_data ({out_valid, out_data}),
    .pop_data  (pop_data),
    .count     (ctx_count),
    .full      (ctx_full),
    .empty     (ctx_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data  <= BUBBLE;
      out_valid <= 1'b0;
      ctx_err   <= 1'b0;
    end else begin
      unique case (act)
        ACT_FLUSH: begin
          out_data  <= BUBBLE;
          out_valid <= 1'b0;
        end
        ACT_SAVE: begin
          out_data  <= BUBBLE;
          out_valid <= 1'b0;
          if (ctx_full) ctx_err <= 1'b1;
        end
        ACT_RESTORE: begin
          if (ctx_empty) begin
            out_data  <= BUBBLE;
            out_valid <= 1'b0;
            ctx_err   <= 1'b1;
          end else begin
            {out_valid, out_data} <= pop_data;
          end
        end
        ACT_LOAD: begin
          out_data  <= in_data;
          out_valid <= in_valid;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/pipe_stage_ctx_reg.md
Name: pipe_stage_ctx_reg

Overview:
Parametrised inter-stage pipeline register for the 5-stage CPU, replacing the fixed 64-bit IF/ID latch. It carries a DATA_W payload plus a valid bit, and supports stall, flush and bubble insertion. It adds a CTX_DEPTH-deep LIFO save/restore stack so that nested interrupts can each park and later restore the stage contents. One instance sits between each pair of stages (IF/ID, ID/EX, ...).

Parameters:
DATA_W, 64, payload width in bits (IF/ID: {inst, pc}).
CTX_DEPTH, 2, number of nested interrupt contexts the stack holds (>=1).
BUBBLE, {DATA_W{1'b0}}, payload value loaded on reset, flush, save, or failed restore.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
in_data  input  DATA_W  payload from the upstream stage
in_valid  input  1  upstream payload is valid
write_en  input  1  load enable; 0 = stall (hold current contents)
flush  input  1  replace contents with a bubble
int_save  input  1  push current {valid, data} onto the context stack and insert a bubble
int_restore  input  1  pop the top context into the register
out_data  output  DATA_W  registered payload to the downstream stage
out_valid  output  1  registered valid bit
ctx_count  output  $clog2(CTX_DEPTH+1)  number of stored contexts
ctx_full  output  1  ctx_count == CTX_DEPTH
ctx_empty  output  1  ctx_count == 0
ctx_err  output  1  sticky: overflow or underflow has occurred

Behaviour:
- All state updates occur on the rising edge of clk. All outputs are registered or decoded from registered state only. Nothing passes combinationally from input to output.
- Reset (reset=0, asynchronous):
  - out_data=BUBBLE, out_valid=0, ctx_count=0, ctx_err=0.
  - Stack storage contents are don't-care.
  - Reset during a save or restore discards every stored context.
- Per-cycle priority, with exactly one action taken: flush > int_save > int_restore > write_en > hold.
  - flush: out_data=BUBBLE, out_valid=0. The stack is untouched, even if int_save or int_restore is also asserted that cycle.
  - int_save:
    - Not full: stack[ctx_count] <= {out_valid, out_data}; ctx_count+1; output becomes bubble.
    - Full: no push, ctx_count unchanged, output still becomes bubble, ctx_err<=1.
  - int_restore:
    - Not empty: {out_valid, out_data} <= stack[ctx_count-1]; ctx_count-1.
    - Empty: output becomes bubble, ctx_err<=1.
  - write_en: out_data<=in_data, out_valid<=in_valid.
  - None of the above: hold.
- Latency: 1 cycle from input to output for loads. Restored contents appear 1 cycle after int_restore.
- The stack is strictly LIFO. The most recent save is restored first.
- ctx_err clears only on reset.
- ctx_full and ctx_empty are decoded from ctx_count.
- Width rules:
  - ctx_count never wraps. It saturates at both 0 and CTX_DEPTH.
  - Stack entry width is DATA_W+1.

Decomposition:
- Shared package pipe_pkg:
  - IF/ID payload width constant IFID_W=64.
  - Bubble constant NOP_BUBBLE.
  - Default CTX_DEPTH constant.
- One natural sub-module: ctx_lifo (parametrised width/depth stack with push, pop, count, full, empty).
- The top-level block holds the output register and the priority logic.

Test Plan:
1. Reset then load: hold reset=0, then release; in_data=64'h0000_0013_0000_0040, in_valid=1, write_en=1 -> next cycle out_data=that value, out_valid=1, ctx_empty=1.
2. Stall and flush:
   - write_en=0 with a new in_data -> out_data holds its prior value.
   - flush=1 together with write_en=1 -> out_data=0, out_valid=0.
3. Nested save/restore, CTX_DEPTH=2:
   - Load A=64'hA, save, load B=64'hB, save -> ctx_count=2, ctx_full=1, output bubble.
   - Restore -> out_data=B.
   - Restore -> out_data=A, ctx_empty=1, ctx_err=0.
4. Overflow and underflow:
   - A third save with the stack full -> ctx_count stays 2, ctx_err=1, output bubble.
   - After draining, restore on empty -> out_valid=0, ctx_count=0, ctx_err remains 1.
5. Simultaneous events:
   - flush+int_save -> ctx_count unchanged.
   - int_save+int_restore -> push only.
   - int_restore+write_en -> restored data wins over in_data.
6. Asynchronous reset mid-context: with ctx_count=1, assert reset=0 between clock edges -> outputs clear immediately, ctx_count=0, ctx_err=0; a subsequent restore yields a bubble and sets ctx_err=1.
